constraint_sweeper: RTL and testbench

//  Owns the chain's point-position store and drives one external enforce_constraint unit.

---
 rtl/constraint_sweeper_if.sv | 38 +++
 rtl/constraint_sweeper.sv | 117 +++++++++++
 tb/tb_constraint_sweeper.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/constraint_sweeper_if.sv
// Host/engine bundle for constraint_sweeper: load/readback port, start/done control
// and the operand/result pair exchanged with the external enforce_constraint unit.
interface constraint_sweeper_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_x;
    logic [31:0]      wr_y;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_x;
    logic [31:0]      rd_y;
    logic [31:0]      ec_up_x;
    logic [31:0]      ec_up_y;
    logic [31:0]      ec_x;
    logic [31:0]      ec_y;
    logic [31:0]      ec_down_x;
    logic [31:0]      ec_down_y;
    logic             ec_is_last;
    logic [31:0]      ec_x_new;
    logic [31:0]      ec_y_new;

    // Master is the host side, which also hosts the enforce_constraint unit
    modport master (
        output start, wr_en, wr_idx, wr_x, wr_y, rd_idx, ec_x_new, ec_y_new,
        input  busy, done, rd_x, rd_y, ec_up_x, ec_up_y, ec_x, ec_y,
               ec_down_x, ec_down_y, ec_is_last
    );

    modport slave (
        input  start, wr_en, wr_idx, wr_x, wr_y, rd_idx, ec_x_new, ec_y_new,
        output busy, done, rd_x, rd_y, ec_up_x, ec_up_y, ec_x, ec_y,
               ec_down_x, ec_down_y, ec_is_last
    );
endinterface

// File: rtl/constraint_sweeper.sv
// In-place (Gauss-Seidel) constraint sweeper: owns the chain point store and walks
// points 1..N_POINTS-1 through one external enforce_constraint unit, ITERATIONS times.
module constraint_sweeper #(
    parameter int N_POINTS      = 16,
    parameter int IDX_W         = 4,
    parameter int ITERATIONS    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    constraint_sweeper_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int IT_W  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_POINTS - 1);
    localparam logic [IT_W-1:0]  LAST_ITER = IT_W'(ITERATIONS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SETTLE, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IT_W-1:0]  iter;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      store_x [DEPTH];
    logic [31:0]      store_y [DEPTH];
    logic [IDX_W-1:0] idx_up;
    logic [IDX_W-1:0] idx_down;
    logic             wr_ok;
    logic             rd_ok;

    // The last point has no downstream neighbour, so it is its own down operand
    assign idx_up   = idx - IDX_W'(1);
    assign idx_down = (idx == LAST_IDX) ? idx : idx + IDX_W'(1);
    assign wr_ok    = int'(bus.wr_idx) < N_POINTS;
    assign rd_ok    = int'(bus.rd_idx) < N_POINTS;

    assign bus.rd_x = rd_ok ? store_x[bus.rd_idx] : '0;
    assign bus.rd_y = rd_ok ? store_y[bus.rd_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            iter           <= '0;
            cnt            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.ec_up_x    <= '0;
            bus.ec_up_y    <= '0;
            bus.ec_x       <= '0;
            bus.ec_y       <= '0;
            bus.ec_down_x  <= '0;
            bus.ec_down_y  <= '0;
            bus.ec_is_last <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                store_x[k] <= '0;
                store_y[k] <= '0;
            end
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_en && wr_ok) begin
                        store_x[bus.wr_idx] <= bus.wr_x;
                        store_y[bus.wr_idx] <= bus.wr_y;
                    end
                    if (bus.start) begin
                        state    <= FETCH;
                        idx      <= IDX_W'(1);
                        iter     <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                FETCH: begin
                    bus.ec_up_x    <= store_x[idx_up];
                    bus.ec_up_y    <= store_y[idx_up];
                    bus.ec_x       <= store_x[idx];
                    bus.ec_y       <= store_y[idx];
                    bus.ec_down_x  <= store_x[idx_down];
                    bus.ec_down_y  <= store_y[idx_down];
                    bus.ec_is_last <= (idx == LAST_IDX);
                    cnt            <= '0;
                    state          <= SETTLE;
                end
                SETTLE: begin
                    // Only the result present on the final settle edge is committed
                    if (cnt == LAST_CNT) begin
                        store_x[idx] <= bus.ec_x_new;
                        store_y[idx] <= bus.ec_y_new;
                        if (idx != LAST_IDX) begin
                            idx   <= idx + IDX_W'(1);
                            state <= FETCH;
                        end else if (iter != LAST_ITER) begin
                            idx   <= IDX_W'(1);
                            iter  <= iter + IT_W'(1);
                            state <= FETCH;
                        end else begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_constraint_sweeper.sv
// Directed bench for constraint_sweeper: four configurations, each with a stub
// enforce_constraint (x_new = up_x + down_x, y_new = y) and a result scoreboard.
module tb_constraint_sweeper;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic glitch_c = 1'b0;

    int total = 0;
    int bad = 0;
    int n;
    int c;
    int pulses;
    int first;

    logic [31:0] mx [4];
    logic [31:0] my [4];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    constraint_sweeper_if #(.IDX_W(2)) ia ();
    constraint_sweeper_if #(.IDX_W(2)) ib ();
    constraint_sweeper_if #(.IDX_W(2)) ic ();
    constraint_sweeper_if #(.IDX_W(3)) id ();

    constraint_sweeper #(.N_POINTS(4), .IDX_W(2), .ITERATIONS(1), .SETTLE_CYCLES(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    constraint_sweeper #(.N_POINTS(4), .IDX_W(2), .ITERATIONS(2), .SETTLE_CYCLES(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    constraint_sweeper #(.N_POINTS(4), .IDX_W(2), .ITERATIONS(1), .SETTLE_CYCLES(3))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    constraint_sweeper #(.N_POINTS(2), .IDX_W(3), .ITERATIONS(1), .SETTLE_CYCLES(1))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(id));

    // Stub units; the C stub returns garbage while glitch_c is raised
    assign ia.ec_x_new = ia.ec_up_x + ia.ec_down_x;
    assign ia.ec_y_new = ia.ec_y;
    assign ib.ec_x_new = ib.ec_up_x + ib.ec_down_x;
    assign ib.ec_y_new = ib.ec_y;
    assign ic.ec_x_new = ic.ec_up_x + ic.ec_down_x + (glitch_c ? 32'h00DE_AD00 : 32'h0);
    assign ic.ec_y_new = ic.ec_y ^ (glitch_c ? 32'h0000_BEEF : 32'h0);
    assign id.ec_x_new = id.ec_up_x + id.ec_down_x;
    assign id.ec_y_new = id.ec_y;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_run(input int np, input int iters);
        for (int it = 0; it < iters; it++) begin
            for (int p = 1; p < np; p++) begin
                mx[p] = mx[p-1] + ((p == np - 1) ? mx[p] : mx[p+1]);
            end
        end
    endtask

    task automatic push_expected(input int np);
        for (int k = 0; k < np; k++) begin
            exp_q.push_back(mx[k]);
            exp_q.push_back(my[k]);
        end
    endtask

    initial begin
        ia.start = 0; ia.wr_en = 0; ia.wr_idx = 0; ia.wr_x = 0; ia.wr_y = 0; ia.rd_idx = 0;
        ib.start = 0; ib.wr_en = 0; ib.wr_idx = 0; ib.wr_x = 0; ib.wr_y = 0; ib.rd_idx = 0;
        ic.start = 0; ic.wr_en = 0; ic.wr_idx = 0; ic.wr_x = 0; ic.wr_y = 0; ic.rd_idx = 0;
        id.start = 0; id.wr_en = 0; id.wr_idx = 0; id.wr_x = 0; id.wr_y = 0; id.rd_idx = 0;

        $display("[TB] reset state");
        step();
        step();
        check_output("rst_busy", 32'(ia.busy), 32'd0);
        check_output("rst_done", 32'(ia.done), 32'd0);
        check_output("rst_ec_x", ia.ec_x, 32'd0);
        check_output("rst_is_last", 32'(ia.ec_is_last), 32'd0);
        rst_n = 1'b1;
        step();

        $display("[TB] A: single sweep N=4 S=1");
        for (int k = 0; k < 4; k++) begin
            ia.wr_en = 1; ia.wr_idx = 2'(k); ia.wr_x = 32'(k + 1); ia.wr_y = 32'h100 + 32'(k);
            mx[k] = 32'(k + 1); my[k] = 32'h100 + 32'(k);
            step();
        end
        ia.wr_en = 0;
        ia.rd_idx = 2;
        #1 check_output("a_load_rd", ia.rd_x, 32'd3);
        ia.start = 1;
        model_run(4, 1);
        push_expected(4);
        step();
        ia.start = 0;
        n = 1;
        check_output("a_busy", 32'(ia.busy), 32'd1);
        while (!ia.done && n < 200) begin step(); n++; end
        check_output("a_latency", 32'(n), 32'd7);
        check_output("a_busy_in_done", 32'(ia.busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            ia.rd_idx = 2'(k);
            #1;
            check_output("a_res_x", ia.rd_x, exp_q.pop_front());
            check_output("a_res_y", ia.rd_y, exp_q.pop_front());
        end
        step();
        check_output("a_done_one_cycle", 32'(ia.done), 32'd0);

        $display("[TB] A: start and write while busy");
        ia.start = 1;
        model_run(4, 1);
        push_expected(4);
        step();
        ia.start = 0;
        pulses = 0;
        first = 0;
        for (int pos = 1; pos < 30; pos++) begin
            if (pos == 3) begin
                check_output("a_busy_mid", 32'(ia.busy), 32'd1);
                ia.start = 1; ia.wr_en = 1; ia.wr_idx = 0; ia.wr_x = 32'hFFFF;
            end else begin
                ia.start = 0; ia.wr_en = 0;
            end
            step();
            if (ia.done) begin
                pulses++;
                if (first == 0) first = pos + 1;
            end
        end
        check_output("a_ignored_latency", 32'(first), 32'd7);
        check_output("a_single_done", 32'(pulses), 32'd1);
        for (int k = 0; k < 4; k++) begin
            ia.rd_idx = 2'(k);
            #1;
            check_output("a_res2_x", ia.rd_x, exp_q.pop_front());
            check_output("a_res2_y", ia.rd_y, exp_q.pop_front());
        end

        $display("[TB] A: asynchronous reset during settle");
        ia.start = 1;
        step();
        ia.start = 0;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_output("ar_busy", 32'(ia.busy), 32'd0);
        check_output("ar_done", 32'(ia.done), 32'd0);
        check_output("ar_ec_x", ia.ec_x, 32'd0);
        check_output("ar_ec_up_x", ia.ec_up_x, 32'd0);
        for (int k = 0; k < 4; k++) begin
            ia.rd_idx = 2'(k);
            #1 check_output("ar_rd_x", ia.rd_x, 32'd0);
        end
        pulses = 0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ia.done) pulses++;
        end
        check_output("ar_no_done", 32'(pulses), 32'd0);

        $display("[TB] B: two sweeps N=4 S=1");
        for (int k = 0; k < 4; k++) begin
            ib.wr_en = 1; ib.wr_idx = 2'(k); ib.wr_x = 32'(k + 1); ib.wr_y = 32'h200 + 32'(k);
            mx[k] = 32'(k + 1); my[k] = 32'h200 + 32'(k);
            step();
        end
        ib.wr_en = 0;
        ib.start = 1;
        model_run(4, 2);
        push_expected(4);
        step();
        ib.start = 0;
        n = 1;
        while (!ib.done && n < 200) begin step(); n++; end
        check_output("b_latency", 32'(n), 32'd13);
        check_output("b_busy_in_done", 32'(ib.busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            ib.rd_idx = 2'(k);
            #1;
            check_output("b_res_x", ib.rd_x, exp_q.pop_front());
            check_output("b_res_y", ib.rd_y, exp_q.pop_front());
        end

        $display("[TB] C: settle S=3 with glitching unit");
        for (int k = 0; k < 4; k++) begin
            ic.wr_en = 1; ic.wr_idx = 2'(k); ic.wr_x = 32'(k + 1); ic.wr_y = 32'h300 + 32'(k);
            mx[k] = 32'(k + 1); my[k] = 32'h300 + 32'(k);
            step();
        end
        ic.wr_en = 0;
        ic.start = 1;
        model_run(4, 1);
        push_expected(4);
        step();
        ic.start = 0;
        c = 0;
        while (!ic.done && c < 200) begin
            step();
            c++;
            glitch_c = ((c % 4) == 1) || ((c % 4) == 2);
            if (c >= 5 && c <= 7) begin
                check_output("c_hold_up_x", ic.ec_up_x, 32'd4);
                check_output("c_hold_x", ic.ec_x, 32'd3);
                check_output("c_hold_down_x", ic.ec_down_x, 32'd4);
            end
        end
        glitch_c = 1'b0;
        check_output("c_latency", 32'(c + 1), 32'd13);
        for (int k = 0; k < 4; k++) begin
            ic.rd_idx = 2'(k);
            #1;
            check_output("c_res_x", ic.rd_x, exp_q.pop_front());
            check_output("c_res_y", ic.rd_y, exp_q.pop_front());
        end

        $display("[TB] D: two-point chain");
        id.wr_en = 1; id.wr_idx = 0; id.wr_x = 32'd10; id.wr_y = 32'd20;
        step();
        id.wr_idx = 1; id.wr_x = 32'd30; id.wr_y = 32'd40;
        step();
        id.wr_idx = 5; id.wr_x = 32'hBAD; id.wr_y = 32'hBAD;
        step();
        id.wr_en = 0;
        mx[0] = 32'd10; my[0] = 32'd20; mx[1] = 32'd30; my[1] = 32'd40;
        id.rd_idx = 5;
        #1 check_output("d_rd_oob", id.rd_x, 32'd0);
        id.rd_idx = 1;
        #1 check_output("d_rd_after_drop", id.rd_x, 32'd30);
        id.start = 1;
        model_run(2, 1);
        push_expected(2);
        step();
        id.start = 0;
        step();
        n = 2;
        check_output("d_is_last", 32'(id.ec_is_last), 32'd1);
        check_output("d_down_eq_cur", id.ec_down_x, 32'd30);
        check_output("d_cur", id.ec_x, 32'd30);
        check_output("d_up", id.ec_up_x, 32'd10);
        while (!id.done && n < 200) begin step(); n++; end
        check_output("d_latency", 32'(n), 32'd3);
        for (int k = 0; k < 2; k++) begin
            id.rd_idx = 3'(k);
            #1;
            check_output("d_res_x", id.rd_x, exp_q.pop_front());
            check_output("d_res_y", id.rd_y, exp_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
